mux_nto1_onehot_reg: RTL and testbench

// - Parametrised, pipelined N-to-1 mux with one-hot select; successor of the 4-input one-hot mux.
// - Adds: generic width/channel count, configurable output latency, valid qualification,

---
 rtl/mux_nto1_onehot_reg.sv | 109 ++++++++++
 tb/tb_mux_nto1_onehot_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_onehot_reg.sv
// Pipelined N-to-1 one-hot mux with valid qualification, illegal-select detection and error status.
// Latency PIPE cycles, one beat per cycle, no backpressure; the error counter saturates at all-ones.
module mux_nto1_onehot_reg #(
  parameter int WIDTH        = 8,
  parameter int NUM_IN       = 4,
  parameter int PIPE         = 1,
  parameter int ILLEGAL_MODE = 0,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        sel,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic                     sel_err,
  output logic                     err_sticky,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  logic             w_seen;
  logic             w_multi;
  logic             w_legal;
  logic [WIDTH-1:0] w_mux;
  logic             w_tail_vld;
  logic             w_tail_err;
  logic [WIDTH-1:0] w_tail_dat;

  // AND-OR mux is exact for legal selects; illegal results are never forwarded.
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    w_mux   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel[k]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
        w_mux  = w_mux | in_data[k*WIDTH +: WIDTH];
      end
    end
    w_legal = w_seen & ~w_multi;
  end

  generate
    if (PIPE == 1) begin : g_direct
      assign w_tail_vld = in_valid;
      assign w_tail_err = in_valid & ~w_legal;
      assign w_tail_dat = w_mux;
    end else begin : g_stages
      logic [PIPE-2:0] r_vld;
      logic [PIPE-2:0] r_err;
      logic [WIDTH-1:0] r_dat [PIPE-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= '0;
          r_err <= '0;
          for (int k = 0; k < PIPE-1; k++) r_dat[k] <= '0;
        end else begin
          r_vld[0] <= in_valid;
          r_err[0] <= in_valid & ~w_legal;
          r_dat[0] <= w_mux;
          for (int k = 1; k < PIPE-1; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_err[k] <= r_err[k-1];
            r_dat[k] <= r_dat[k-1];
          end
        end
      end

      assign w_tail_vld = r_vld[PIPE-2];
      assign w_tail_err = r_err[PIPE-2];
      assign w_tail_dat = r_dat[PIPE-2];
    end
  endgenerate

  // Final stage owns the hold-previous behaviour, so holds refer to the visible output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      out_valid <= w_tail_vld;
      sel_err   <= w_tail_vld & w_tail_err;
      if (w_tail_vld) begin
        if (!w_tail_err)            out_data <= w_tail_dat;
        else if (ILLEGAL_MODE != 0) out_data <= '0;
      end
    end
  end

  // A clear coinciding with an error beat leaves that beat counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (err_clr) begin
      err_sticky <= sel_err;
      err_cnt    <= ERR_CNT_W'(sel_err);
    end else if (sel_err) begin
      err_sticky <= 1'b1;
      if (~&err_cnt) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_nto1_onehot_reg.sv
// Bench for mux_nto1_onehot_reg: three configurations share one stimulus stream and a queue-based model.
module tb_mux_nto1_onehot_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  sel = '0;

  always #5 clk = ~clk;

  logic [7:0] a_data, b_data, c_data;
  logic       a_vld, b_vld, c_vld, a_err, b_err, c_err, a_stk, b_stk, c_stk;
  logic [7:0] a_cnt, c_cnt;
  logic [1:0] b_cnt;

  mux_nto1_onehot_reg #(.WIDTH(8), .NUM_IN(4), .PIPE(1), .ILLEGAL_MODE(0), .ERR_CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sel(sel), .err_clr(err_clr),
    .out_data(a_data), .out_valid(a_vld), .sel_err(a_err), .err_sticky(a_stk), .err_cnt(a_cnt));
  mux_nto1_onehot_reg #(.WIDTH(8), .NUM_IN(4), .PIPE(2), .ILLEGAL_MODE(1), .ERR_CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sel(sel), .err_clr(err_clr),
    .out_data(b_data), .out_valid(b_vld), .sel_err(b_err), .err_sticky(b_stk), .err_cnt(b_cnt));
  mux_nto1_onehot_reg #(.WIDTH(8), .NUM_IN(4), .PIPE(3), .ILLEGAL_MODE(0), .ERR_CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sel(sel), .err_clr(err_clr),
    .out_data(c_data), .out_valid(c_vld), .sel_err(c_err), .err_sticky(c_stk), .err_cnt(c_cnt));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance's output after edge e is the beat sampled at edge e-(PIPE-1).
  int pipe_of [3] = '{1, 2, 3};
  int mode_of [3] = '{0, 1, 0};
  int cmax_of [3] = '{255, 3, 255};

  logic        hv [$];
  logic [31:0] hd [$];
  logic [3:0]  hs [$];

  logic [7:0] m_dat [3];
  logic       m_vld [3];
  logic       m_err [3];
  logic       m_stk [3];
  int         m_cnt [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hv.delete(); hd.delete(); hs.delete();
      for (int i = 0; i < 3; i++) begin
        m_dat[i] = '0; m_vld[i] = 1'b0; m_err[i] = 1'b0; m_stk[i] = 1'b0; m_cnt[i] = 0;
      end
    end else begin
      int e;
      hv.push_back(in_valid); hd.push_back(in_data); hs.push_back(sel);
      e = hv.size() - 1;
      for (int i = 0; i < 3; i++) begin
        int b;
        if (err_clr) begin
          m_cnt[i] = m_err[i] ? 1 : 0;
          m_stk[i] = m_err[i];
        end else if (m_err[i]) begin
          m_stk[i] = 1'b1;
          if (m_cnt[i] < cmax_of[i]) m_cnt[i] = m_cnt[i] + 1;
        end
        b = e - (pipe_of[i] - 1);
        if (b >= 0 && hv[b]) begin
          m_vld[i] = 1'b1;
          m_err[i] = ($countones(hs[b]) != 1);
          if (!m_err[i]) begin
            for (int k = 0; k < 4; k++)
              if (hs[b][k]) m_dat[i] = hd[b][k*8 +: 8];
          end else if (mode_of[i] == 1) begin
            m_dat[i] = 8'h00;
          end
        end else begin
          m_vld[i] = 1'b0;
          m_err[i] = 1'b0;
        end
      end
    end
  end

  logic [7:0] o_dat [3];
  logic       o_vld [3];
  logic       o_err [3];
  logic       o_stk [3];
  logic [7:0] o_cnt [3];
  assign o_dat[0] = a_data; assign o_dat[1] = b_data; assign o_dat[2] = c_data;
  assign o_vld[0] = a_vld;  assign o_vld[1] = b_vld;  assign o_vld[2] = c_vld;
  assign o_err[0] = a_err;  assign o_err[1] = b_err;  assign o_err[2] = c_err;
  assign o_stk[0] = a_stk;  assign o_stk[1] = b_stk;  assign o_stk[2] = c_stk;
  assign o_cnt[0] = a_cnt;  assign o_cnt[1] = {6'd0, b_cnt}; assign o_cnt[2] = c_cnt;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_data[%0d]", i),   32'(o_dat[i]), 32'(m_dat[i]));
      check($sformatf("model_valid[%0d]", i),  32'(o_vld[i]), 32'(m_vld[i]));
      check($sformatf("model_selerr[%0d]", i), 32'(o_err[i]), 32'(m_err[i]));
      check($sformatf("model_sticky[%0d]", i), 32'(o_stk[i]), 32'(m_stk[i]));
      check($sformatf("model_cnt[%0d]", i),    32'(o_cnt[i]), 32'(m_cnt[i]));
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] s, input logic c);
    in_valid = v; in_data = d; sel = s; err_clr = c;
    @(negedge clk);
  endtask

  localparam logic [31:0] D = 32'hDDCCBBAA;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a_valid", 32'(a_vld), 0);
    check("rst_a_data", 32'(a_data), 0);
    check("rst_b_cnt", 32'(b_cnt), 0);
    check("rst_c_sticky", 32'(c_stk), 0);
    rst = 1'b0;

    // Legal sweep
    drive(1, D, 4'b0001, 0); check("sweep_aa", 32'(a_data), 32'hAA); check("sweep_vld", 32'(a_vld), 1);
    drive(1, D, 4'b0010, 0); check("sweep_bb", 32'(a_data), 32'hBB);
    drive(1, D, 4'b0100, 0); check("sweep_cc", 32'(a_data), 32'hCC);
    drive(1, D, 4'b1000, 0); check("sweep_dd", 32'(a_data), 32'hDD); check("sweep_err", 32'(a_err), 0);
    check("sweep_b_pipe2", 32'(b_data), 32'hCC);
    check("sweep_c_pipe3", 32'(c_data), 32'hBB);
    repeat (3) drive(0, 32'h0, 4'b0000, 0);
    check("idle_a_hold", 32'(a_data), 32'hDD);
    check("idle_c_hold", 32'(c_data), 32'hDD);
    check("idle_c_vld", 32'(c_vld), 0);

    // Illegal selects: hold (A) versus zero (B)
    drive(1, 32'h005A0000, 4'b0100, 0); check("ill_a_5a", 32'(a_data), 32'h5A);
    drive(1, 32'hFFFFFFFF, 4'b0000, 0); check("ill0_a_hold", 32'(a_data), 32'h5A); check("ill0_a_err", 32'(a_err), 1);
    drive(1, 32'h11223344, 4'b0110, 0); check("ill1_a_hold", 32'(a_data), 32'h5A); check("ill1_a_err", 32'(a_err), 1);
    check("ill_b_zero", 32'(b_data), 32'h00); check("ill_b_err", 32'(b_err), 1);
    drive(0, 32'h0, 4'b0000, 0);
    check("ill_a_cnt", 32'(a_cnt), 2); check("ill_a_sticky", 32'(a_stk), 1);
    drive(1, D, 4'b1100, 0);
    drive(0, 32'h0, 4'b0000, 0);
    check("m1_b_data", 32'(b_data), 32'h00); check("m1_b_err", 32'(b_err), 1); check("m1_b_vld", 32'(b_vld), 1);

    // Saturation and clear on the 2-bit counter
    repeat (5) drive(1, D, 4'b1100, 0);
    repeat (3) drive(0, 32'h0, 4'b0000, 0);
    check("sat_b_cnt", 32'(b_cnt), 3); check("sat_b_sticky", 32'(b_stk), 1);
    drive(0, 32'h0, 4'b0000, 1);
    check("clr_b_cnt", 32'(b_cnt), 0); check("clr_b_sticky", 32'(b_stk), 0); check("clr_a_cnt", 32'(a_cnt), 0);
    drive(1, D, 4'b1100, 0);
    drive(0, 32'h0, 4'b0000, 0);
    drive(0, 32'h0, 4'b0000, 1);
    check("clrerr_b_cnt", 32'(b_cnt), 1); check("clrerr_b_sticky", 32'(b_stk), 1);
    check("clrerr_a_cnt", 32'(a_cnt), 0);

    // Latency and idle behaviour at PIPE=3
    repeat (3) drive(0, 32'h0, 4'b0000, 0);
    drive(1, 32'h44332211, 4'b0001, 0);
    drive(0, 32'h99999999, 4'b0001, 0); check("lat_c_vld_early", 32'(c_vld), 0);
    drive(1, 32'h88776655, 4'b0010, 0); check("lat_c_vld", 32'(c_vld), 1); check("lat_c_data", 32'(c_data), 32'h11);
    drive(0, 32'h99999999, 4'b0100, 0); check("lat_c_gap", 32'(c_vld), 0); check("lat_c_hold", 32'(c_data), 32'h11);
    drive(1, D, 4'b0100, 0); check("lat_c_data2", 32'(c_data), 32'h66);
    for (int j = 0; j < 6; j++) drive(j[0] ? 1'b0 : 1'b1, D + 32'(j), 4'(1 << (j % 4)), 0);
    repeat (4) drive(0, 32'h0, 4'b0000, 0);
    check("idle_sel0_c_err", 32'(c_err), 0);

    // Reset mid-stream
    drive(1, D, 4'b1000, 0);
    drive(1, D, 4'b1000, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_b_vld", 32'(b_vld), 0); check("mid_rst_b_data", 32'(b_data), 0);
    check("mid_rst_b_cnt", 32'(b_cnt), 0); check("mid_rst_a_data", 32'(a_data), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, D, 4'b0010, 0); check("post_rst_b_vld0", 32'(b_vld), 0);
    drive(1, D, 4'b0100, 0); check("post_rst_b_vld1", 32'(b_vld), 1); check("post_rst_b_data", 32'(b_data), 32'hBB);
    repeat (3) drive(0, 32'h0, 4'b0000, 0);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
